// File: rtl/dice_pkg.sv
// Shared constants for the multi-die roller: die-type indices, face table,
// FSM state encoding and LFSR geometry.
package dice_pkg;

    localparam int LFSR_W    = 32;
    localparam int VAL_W     = 7;
    localparam int SUM_W     = 9;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 8;
    localparam int NUM_TYPES = 7;

    localparam logic [SEL_W-1:0] DIE_D4   = 3'd0;
    localparam logic [SEL_W-1:0] DIE_D6   = 3'd1;
    localparam logic [SEL_W-1:0] DIE_D8   = 3'd2;
    localparam logic [SEL_W-1:0] DIE_D10  = 3'd3;
    localparam logic [SEL_W-1:0] DIE_D12  = 3'd4;
    localparam logic [SEL_W-1:0] DIE_D20  = 3'd5;
    localparam logic [SEL_W-1:0] DIE_D100 = 3'd6;

    // Feedback taps 32,22,2,1 expressed as a mask over state bits 31,21,1,0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_SUMMING = 2'd2
    } state_e;

    // Unused encoding 7 maps to a nonzero face count so the modulo never divides by zero.
    function automatic logic [VAL_W-1:0] faceCount(input logic [SEL_W-1:0] sel);
        logic [VAL_W-1:0] f;
        case (sel)
            DIE_D4:   f = 7'd4;
            DIE_D6:   f = 7'd6;
            DIE_D8:   f = 7'd8;
            DIE_D10:  f = 7'd10;
            DIE_D12:  f = 7'd12;
            DIE_D20:  f = 7'd20;
            DIE_D100: f = 7'd100;
            default:  f = 7'd4;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 32-bit Fibonacci LFSR; it shifts every clock regardless of
// what the roller is doing, so roll outcomes depend on key timing.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2468
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/multi_dice_roller.sv
// Multi-die roller: inc/dec keys pick a die type, the roll key animates
// NUM_DICE dice from the LFSR, then the final values and their sum are published.
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int                NUM_DICE     = 2,
    parameter int                ROLL_CYCLES  = 8,
    parameter int                DEFAULT_DICE = 1,
    parameter logic [LFSR_W-1:0] SEED         = 32'hACE1_2468
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      key_inc,
    input  logic                      key_dec,
    input  logic                      key_roll,
    output logic [SEL_W-1:0]          dice_sel,
    output logic [VAL_W-1:0]          faces,
    output logic [VAL_W*NUM_DICE-1:0] values,
    output logic [SUM_W-1:0]          sum,
    output logic                      busy,
    output logic                      valid
);

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ROLL_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_RESET = SEL_W'(DEFAULT_DICE);

    state_e                    state_q;
    logic [SEL_W-1:0]          sel_q;
    logic [VAL_W*NUM_DICE-1:0] values_q;
    logic [SUM_W-1:0]          sum_q;
    logic                      busy_q;
    logic                      valid_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      incPrev_q;
    logic                      decPrev_q;
    logic                      rollPrev_q;

    logic [LFSR_W-1:0]         lfsrState;
    logic [VAL_W-1:0]          facesCur;
    logic                      incEdge;
    logic                      decEdge;
    logic                      rollEdge;
    logic [VAL_W*NUM_DICE-1:0] rollVals_d;
    logic [SUM_W-1:0]          sum_d;

    dice_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .Clk    (Clk),
        .Rst    (Rst),
        .state_o(lfsrState)
    );

    assign facesCur = faceCount(sel_q);
    assign incEdge  = key_inc  & ~incPrev_q;
    assign decEdge  = key_dec  & ~decPrev_q;
    assign rollEdge = key_roll & ~rollPrev_q;

    // Each die takes its own 7-bit slice of the LFSR; the modulo bias is tolerated.
    always_comb begin
        rollVals_d = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            rollVals_d[VAL_W*i +: VAL_W] = (lfsrState[VAL_W*i +: VAL_W] % facesCur) + 7'd1;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            sum_d = sum_d + SUM_W'(values_q[VAL_W*i +: VAL_W]);
        end
    end

    // Previous-key registers reset high so a key already held at reset release is not an edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_RESET;
            values_q   <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            incPrev_q  <= 1'b1;
            decPrev_q  <= 1'b1;
            rollPrev_q <= 1'b1;
        end else begin
            incPrev_q  <= key_inc;
            decPrev_q  <= key_dec;
            rollPrev_q <= key_roll;
            case (state_q)
                ST_IDLE: begin
                    if (rollEdge) begin
                        state_q <= ST_ROLLING;
                        cnt_q   <= CNT_LOAD;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (incEdge && !decEdge) begin
                        sel_q    <= (sel_q == DIE_D100) ? DIE_D4 : sel_q + 3'd1;
                        values_q <= '0;
                        sum_q    <= '0;
                        valid_q  <= 1'b0;
                    end else if (decEdge && !incEdge) begin
                        sel_q    <= (sel_q == DIE_D4) ? DIE_D100 : sel_q - 3'd1;
                        values_q <= '0;
                        sum_q    <= '0;
                        valid_q  <= 1'b0;
                    end
                end
                ST_ROLLING: begin
                    values_q <= rollVals_d;
                    if (cnt_q == '0) begin
                        state_q <= ST_SUMMING;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_SUMMING: begin
                    sum_q   <= sum_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dice_sel = sel_q;
    assign faces    = facesCur;
    assign values   = values_q;
    assign sum      = sum_q;
    assign busy     = busy_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_multi_dice_roller.sv
// Self-checking bench for multi_dice_roller: two instances (2 and 4 dice) share
// keys and reset; results are predicted from an arithmetic LFSR/dice model.
module tb_multi_dice_roller;

    localparam int          RC    = 8;
    localparam logic [31:0] SEED2 = 32'hACE1_2468;
    localparam logic [31:0] SEED4 = 32'h1357_9BDF;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        key_inc = 1'b0;
    logic        key_dec = 1'b0;
    logic        key_roll = 1'b0;

    logic [2:0]  sel2, sel4;
    logic [6:0]  faces2, faces4;
    logic [13:0] values2;
    logic [27:0] values4;
    logic [8:0]  sum2, sum4;
    logic        busy2, busy4, valid2, valid4;

    int          total = 0;
    int          bad = 0;
    int          expSel = 1;
    logic [31:0] m2, m4;

    multi_dice_roller #(
        .NUM_DICE(2), .ROLL_CYCLES(RC), .DEFAULT_DICE(1), .SEED(SEED2)
    ) dut2 (
        .Clk(Clk), .Rst(Rst), .key_inc(key_inc), .key_dec(key_dec), .key_roll(key_roll),
        .dice_sel(sel2), .faces(faces2), .values(values2), .sum(sum2),
        .busy(busy2), .valid(valid2)
    );

    multi_dice_roller #(
        .NUM_DICE(4), .ROLL_CYCLES(RC), .DEFAULT_DICE(1), .SEED(SEED4)
    ) dut4 (
        .Clk(Clk), .Rst(Rst), .key_inc(key_inc), .key_dec(key_dec), .key_roll(key_roll),
        .dice_sel(sel4), .faces(faces4), .values(values4), .sum(sum4),
        .busy(busy4), .valid(valid4)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] nextLfsr(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Reference generator: the LFSR advances on every clock out of reset.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m2 <= SEED2;
            m4 <= SEED4;
        end else begin
            m2 <= nextLfsr(m2);
            m4 <= nextLfsr(m4);
        end
    end

    function automatic int faceOf(input int sel);
        int table_f[7] = '{4, 6, 8, 10, 12, 20, 100};
        return table_f[sel];
    endfunction

    function automatic logic [27:0] expVals(input logic [31:0] s, input int n, input int f);
        logic [27:0] r;
        int slice;
        r = '0;
        for (int i = 0; i < n; i++) begin
            slice = int'((s >> (7 * i)) & 32'h7F);
            r[7*i +: 7] = 7'((slice % f) + 1);
        end
        return r;
    endfunction

    function automatic logic [8:0] valsSum(input logic [27:0] v, input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(v[7*i +: 7]);
        return 9'(s);
    endfunction

    task automatic pulseKeys(input bit inc, input bit dec);
        @(negedge Clk);
        key_inc = inc;
        key_dec = dec;
        @(negedge Clk);
        key_inc = 1'b0;
        key_dec = 1'b0;
        if (inc && !dec) expSel = (expSel + 1) % 7;
        if (dec && !inc) expSel = (expSel + 6) % 7;
    endtask

    task automatic selectDie(input int target);
        for (int i = 0; i < 7 && expSel != target; i++) pulseKeys(1'b1, 1'b0);
    endtask

    // Runs one roll and reports busy lengths plus the generator state seen by the final rolling edge.
    task automatic doRoll(input bit inject, input bit incOnRoll,
                          output int b2, output int b4,
                          output logic [31:0] s2, output logic [31:0] s4);
        b2 = 0;
        b4 = 0;
        s2 = '0;
        s4 = '0;
        @(negedge Clk);
        key_roll = 1'b1;
        key_inc  = incOnRoll;
        @(negedge Clk);
        key_roll = 1'b0;
        key_inc  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == RC) begin
                s2 = m2;
                s4 = m4;
            end
            if (inject && k == 3) begin
                key_roll = 1'b1;
                key_inc  = 1'b1;
            end
            if (inject && k == 4) begin
                key_roll = 1'b0;
                key_inc  = 1'b0;
            end
            if (busy2) b2++;
            if (busy4) b4++;
            if (!busy2 && !busy4) break;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        total++; if (sel2 !== 3'd1) begin bad++; $display("[TB] FAIL reset_sel2: got %0d want 1", sel2); end
        total++; if (sel4 !== 3'd1) begin bad++; $display("[TB] FAIL reset_sel4: got %0d want 1", sel4); end
        total++; if (faces2 !== 7'd6) begin bad++; $display("[TB] FAIL reset_faces: got %0d want 6", faces2); end
        total++; if (values2 !== 14'd0 || values4 !== 28'd0) begin bad++; $display("[TB] FAIL reset_values: got %h/%h want 0", values2, values4); end
        total++; if (sum2 !== 9'd0 || sum4 !== 9'd0) begin bad++; $display("[TB] FAIL reset_sum: got %0d/%0d want 0", sum2, sum4); end
        total++; if (busy2 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b/%b want 0", busy2, busy4); end
        total++; if (valid2 !== 1'b0 || valid4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b/%b want 0", valid2, valid4); end
    endtask

    task automatic test_select();
        int seq[7] = '{2, 3, 4, 5, 6, 0, 1};
        int op;
        for (int i = 0; i < 7; i++) begin
            pulseKeys(1'b1, 1'b0);
            total++;
            if (sel2 !== 3'(seq[i]) || sel4 !== 3'(seq[i])) begin
                bad++; $display("[TB] FAIL inc_seq[%0d]: got %0d/%0d want %0d", i, sel2, sel4, seq[i]);
            end
            total++;
            if (faces4 !== 7'(faceOf(seq[i]))) begin
                bad++; $display("[TB] FAIL inc_faces[%0d]: got %0d want %0d", i, faces4, faceOf(seq[i]));
            end
        end
        selectDie(0);
        pulseKeys(1'b0, 1'b1);
        total++; if (sel2 !== 3'd6) begin bad++; $display("[TB] FAIL dec_wrap: got %0d want 6", sel2); end
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 3);
            pulseKeys(op[0], op[1]);
            total++;
            if (sel2 !== 3'(expSel) || sel4 !== 3'(expSel) || faces2 !== 7'(faceOf(expSel))) begin
                bad++; $display("[TB] FAIL rand_sel[%0d] op=%0d: got %0d/%0d faces %0d want %0d", i, op, sel2, sel4, faces2, expSel);
            end
        end
    endtask

    task automatic test_roll_d6();
        int b2, b4;
        logic [31:0] s2, s4;
        logic [27:0] e2, e4;
        selectDie(1);
        doRoll(1'b0, 1'b0, b2, b4, s2, s4);
        e2 = expVals(s2, 2, 6);
        e4 = expVals(s4, 4, 6);
        total++; if (b2 != RC + 1 || b4 != RC + 1) begin bad++; $display("[TB] FAIL d6_busy_len: got %0d/%0d want %0d", b2, b4, RC + 1); end
        total++; if (values2 !== e2[13:0]) begin bad++; $display("[TB] FAIL d6_values2: got %h want %h", values2, e2[13:0]); end
        total++; if (values4 !== e4) begin bad++; $display("[TB] FAIL d6_values4: got %h want %h", values4, e4); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (values2[7*i +: 7] < 7'd1 || values2[7*i +: 7] > 7'd6) begin
                bad++; $display("[TB] FAIL d6_range[%0d]: got %0d want 1..6", i, values2[7*i +: 7]);
            end
        end
        total++; if (sum2 !== 9'(values2[6:0]) + 9'(values2[13:7])) begin bad++; $display("[TB] FAIL d6_sum_self: got %0d want %0d", sum2, 9'(values2[6:0]) + 9'(values2[13:7])); end
        total++; if (sum2 !== valsSum(e2, 2)) begin bad++; $display("[TB] FAIL d6_sum2: got %0d want %0d", sum2, valsSum(e2, 2)); end
        total++; if (sum4 !== valsSum(e4, 4)) begin bad++; $display("[TB] FAIL d6_sum4: got %0d want %0d", sum4, valsSum(e4, 4)); end
        total++; if (valid2 !== 1'b1 || valid4 !== 1'b1) begin bad++; $display("[TB] FAIL d6_valid: got %b/%b want 1", valid2, valid4); end
    endtask

    task automatic test_selection_clears();
        pulseKeys(1'b0, 1'b1);
        total++; if (sel2 !== 3'(expSel)) begin bad++; $display("[TB] FAIL clr_sel: got %0d want %0d", sel2, expSel); end
        total++; if (valid2 !== 1'b0 || valid4 !== 1'b0) begin bad++; $display("[TB] FAIL clr_valid: got %b/%b want 0", valid2, valid4); end
        total++; if (values2 !== 14'd0 || values4 !== 28'd0) begin bad++; $display("[TB] FAIL clr_values: got %h/%h want 0", values2, values4); end
        total++; if (sum2 !== 9'd0 || sum4 !== 9'd0) begin bad++; $display("[TB] FAIL clr_sum: got %0d/%0d want 0", sum2, sum4); end
    endtask

    task automatic test_ignore_keys();
        int b2, b4;
        logic [31:0] s2, s4;
        logic [27:0] e2, e4;
        logic [13:0] held;
        selectDie($urandom_range(0, 6));
        doRoll(1'b1, 1'b0, b2, b4, s2, s4);
        e2 = expVals(s2, 2, faceOf(expSel));
        total++; if (sel2 !== 3'(expSel)) begin bad++; $display("[TB] FAIL busy_inc_sel: got %0d want %0d", sel2, expSel); end
        total++; if (b2 != RC + 1) begin bad++; $display("[TB] FAIL busy_roll_len: got %0d want %0d", b2, RC + 1); end
        total++; if (values2 !== e2[13:0]) begin bad++; $display("[TB] FAIL busy_values: got %h want %h", values2, e2[13:0]); end
        held = values2;
        pulseKeys(1'b1, 1'b1);
        total++; if (sel2 !== 3'(expSel) || valid2 !== 1'b1 || values2 !== held) begin
            bad++; $display("[TB] FAIL incdec_same: got sel %0d valid %b vals %h want sel %0d valid 1 vals %h", sel2, valid2, values2, expSel, held);
        end
        doRoll(1'b0, 1'b1, b2, b4, s2, s4);
        e4 = expVals(s4, 4, faceOf(expSel));
        total++; if (sel4 !== 3'(expSel)) begin bad++; $display("[TB] FAIL roll_prio_sel: got %0d want %0d", sel4, expSel); end
        total++; if (b4 != RC + 1 || values4 !== e4) begin bad++; $display("[TB] FAIL roll_prio_roll: got len %0d vals %h want %0d %h", b4, values4, RC + 1, e4); end
    endtask

    task automatic test_reset_midroll();
        int b2, b4;
        logic [31:0] s2, s4;
        logic [27:0] e2;
        selectDie($urandom_range(2, 6));
        @(negedge Clk);
        key_roll = 1'b1;
        @(negedge Clk);
        key_roll = 1'b0;
        repeat (3) @(negedge Clk);
        total++; if (busy2 !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy: got %b want 1", busy2); end
        Rst = 1'b1;
        #1;
        expSel = 1;
        total++; if (busy2 !== 1'b0 || busy4 !== 1'b0 || valid2 !== 1'b0 || valid4 !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_rst_flags: got busy %b%b valid %b%b want 0", busy2, busy4, valid2, valid4);
        end
        total++; if (values2 !== 14'd0 || values4 !== 28'd0 || sum2 !== 9'd0 || sum4 !== 9'd0) begin
            bad++; $display("[TB] FAIL mid_rst_data: got %h/%h sum %0d/%0d want 0", values2, values4, sum2, sum4);
        end
        total++; if (sel2 !== 3'd1 || faces2 !== 7'd6) begin bad++; $display("[TB] FAIL mid_rst_sel: got %0d faces %0d want 1/6", sel2, faces2); end
        key_roll = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            total++;
            if (busy2 !== 1'b0 || busy4 !== 1'b0) begin bad++; $display("[TB] FAIL held_roll[%0d]: got busy %b/%b want 0", i, busy2, busy4); end
        end
        key_roll = 1'b0;
        doRoll(1'b0, 1'b0, b2, b4, s2, s4);
        e2 = expVals(s2, 2, 6);
        total++; if (values2 !== e2[13:0]) begin bad++; $display("[TB] FAIL post_rst_values: got %h want %h", values2, e2[13:0]); end
    endtask

    task automatic test_d100();
        int b2, b4;
        logic [31:0] s2, s4;
        logic [27:0] e2, e4;
        bit hits[101];
        int missing;
        int v;
        for (int i = 0; i <= 100; i++) hits[i] = 1'b0;
        selectDie(6);
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            doRoll(1'b0, 1'b0, b2, b4, s2, s4);
            e2 = expVals(s2, 2, 100);
            e4 = expVals(s4, 4, 100);
            total++;
            if (values4 !== e4 || sum4 !== valsSum(e4, 4) || valid4 !== 1'b1) begin
                bad++; $display("[TB] FAIL d100_roll4[%0d]: got %h sum %0d valid %b want %h sum %0d valid 1", r, values4, sum4, valid4, e4, valsSum(e4, 4));
            end
            total++;
            if (values2 !== e2[13:0] || sum2 !== valsSum(e2, 2)) begin
                bad++; $display("[TB] FAIL d100_roll2[%0d]: got %h sum %0d want %h sum %0d", r, values2, sum2, e2[13:0], valsSum(e2, 2));
            end
            total++;
            if (sum4 > 9'd400) begin bad++; $display("[TB] FAIL d100_sum_max[%0d]: got %0d want <=400", r, sum4); end
            for (int d = 0; d < 4; d++) begin
                v = int'(values4[7*d +: 7]);
                if (v >= 1 && v <= 100) hits[v] = 1'b1;
            end
        end
        missing = 0;
        for (int i = 1; i <= 100; i++) if (!hits[i]) missing++;
        total++; if (missing != 0) begin bad++; $display("[TB] FAIL d100_coverage: got %0d faces unseen want 0", missing); end
    endtask

    initial begin
        test_reset();
        test_select();
        test_roll_d6();
        test_selection_clears();
        test_ignore_keys();
        test_reset_midroll();
        test_d100();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
